// File: rtl/calculadora_pkg.sv
// Shared definitions for the 8-bit calculator and its input sequencer:
// opcode values, sequencer state encoding and opcode validation.
package calculadora_pkg;

    localparam logic [2:0] ZERAR    = 3'b000;
    localparam logic [2:0] MOSTRA_A = 3'b001;
    localparam logic [2:0] MOSTRA_B = 3'b010;
    localparam logic [2:0] SOMAR    = 3'b011;
    localparam logic [2:0] SUBTRAIR = 3'b100;
    localparam logic [2:0] COD_MAX  = 3'b100;

    typedef enum logic [2:0] {
        ESPERA_A,
        ESPERA_B,
        ESPERA_COD,
        CALCULA,
        RESULTADO
    } estado_t;

    // A byte is a legal opcode only if its upper bits are clear and it names a known operation.
    function automatic logic opcode_valido(input logic [7:0] b);
        return (b[7:3] == 5'd0) && (b[2:0] <= COD_MAX);
    endfunction

endpackage

// File: rtl/sequenciador_calculadora_if.sv
// Byte-stream handshake into the sequencer (A, B, opcode) plus the
// request to reuse the previous result as operand A.
interface sequenciador_calculadora_if;

    logic [7:0] dado_in;
    logic       dado_valido;
    logic       dado_pronto;
    logic       usar_ultimo;

    modport master (
        output dado_in,
        output dado_valido,
        output usar_ultimo,
        input  dado_pronto
    );

    modport slave (
        input  dado_in,
        input  dado_valido,
        input  usar_ultimo,
        output dado_pronto
    );

endinterface

// File: rtl/temporizador_inatividade.sv
// Idle-cycle counter: flags estouro on the idle cycle that would bring the
// count to TIMEOUT. TIMEOUT = 0 builds no counter at all.
module temporizador_inatividade #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic contar,
    input  logic limpar,
    output logic estouro
);

    generate
        if (TIMEOUT > 0) begin : g_contador
            localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

            logic [W-1:0] contagem;

            assign estouro = contar && (contagem == W'(TIMEOUT - 1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    contagem <= '0;
                end else if (limpar || estouro) begin
                    contagem <= '0;
                end else if (contar) begin
                    contagem <= contagem + 1'b1;
                end
            end
        end else begin : g_sem_contador
            assign estouro = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/sequenciador_calculadora.sv
// Collects A, B and opcode from a byte stream, drives them registered into
// the combinational calculator and captures its output one cycle later.
//
// state      | meaning
// ESPERA_A   | waiting for operand A (byte, or previous result via usar_ultimo)
// ESPERA_B   | waiting for operand B; idle timeout armed
// ESPERA_COD | waiting for opcode; idle timeout armed
// CALCULA    | calculator inputs settled; capture saida_calc at closing edge
// RESULTADO  | resultado_valido high for this cycle
module sequenciador_calculadora
    import calculadora_pkg::*;
#(
    parameter int TIMEOUT = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    sequenciador_calculadora_if.slave    fluxo,
    output logic [7:0]                   entrada_A,
    output logic [7:0]                   entrada_B,
    output logic [2:0]                   codigo,
    input  logic [7:0]                   saida_calc,
    output logic [7:0]                   resultado,
    output logic                         resultado_valido,
    output logic                         erro,
    output logic                         expirou
);

    estado_t estado, estado_prox;
    logic    pronto;
    logic    carrega_a_dado, carrega_a_ult, carrega_b, carrega_cod, captura;
    logic    contar, limpar, estouro;
    logic    erro_pend;

    assign fluxo.dado_pronto = pronto;

    // Idle only counts while waiting for B or opcode and nothing is offered.
    assign contar = ((estado == ESPERA_B) || (estado == ESPERA_COD)) && !fluxo.dado_valido;
    assign limpar = (estado_prox != estado);

    temporizador_inatividade #(.TIMEOUT(TIMEOUT)) u_temporizador (
        .clk     (clk),
        .rst     (rst),
        .contar  (contar),
        .limpar  (limpar),
        .estouro (estouro)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= ESPERA_A;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox    = estado;
        pronto         = 1'b0;
        carrega_a_dado = 1'b0;
        carrega_a_ult  = 1'b0;
        carrega_b      = 1'b0;
        carrega_cod    = 1'b0;
        captura        = 1'b0;
        case (estado)
            ESPERA_A: begin
                pronto = ~fluxo.usar_ultimo;
                if (fluxo.usar_ultimo) begin
                    carrega_a_ult = 1'b1;
                    estado_prox   = ESPERA_B;
                end else if (fluxo.dado_valido) begin
                    carrega_a_dado = 1'b1;
                    estado_prox    = ESPERA_B;
                end
            end
            ESPERA_B: begin
                pronto = 1'b1;
                if (fluxo.dado_valido) begin
                    carrega_b   = 1'b1;
                    estado_prox = ESPERA_COD;
                end else if (estouro) begin
                    estado_prox = ESPERA_A;
                end
            end
            ESPERA_COD: begin
                pronto = 1'b1;
                if (fluxo.dado_valido) begin
                    carrega_cod = 1'b1;
                    estado_prox = CALCULA;
                end else if (estouro) begin
                    estado_prox = ESPERA_A;
                end
            end
            CALCULA: begin
                captura     = 1'b1;
                estado_prox = RESULTADO;
            end
            RESULTADO: begin
                estado_prox = ESPERA_A;
            end
            default: begin
                estado_prox = ESPERA_A;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entrada_A        <= 8'h00;
            entrada_B        <= 8'h00;
            codigo           <= ZERAR;
            resultado        <= 8'h00;
            resultado_valido <= 1'b0;
            erro             <= 1'b0;
            erro_pend        <= 1'b0;
            expirou          <= 1'b0;
        end else begin
            if (carrega_a_ult) begin
                entrada_A <= resultado;
            end else if (carrega_a_dado) begin
                entrada_A <= fluxo.dado_in;
            end
            if (carrega_b) begin
                entrada_B <= fluxo.dado_in;
            end
            // An illegal opcode becomes ZERAR so the calculator output is a clean 0x00.
            if (carrega_cod) begin
                if (opcode_valido(fluxo.dado_in)) begin
                    codigo    <= fluxo.dado_in[2:0];
                    erro_pend <= 1'b0;
                end else begin
                    codigo    <= ZERAR;
                    erro_pend <= 1'b1;
                end
            end
            if (captura) begin
                resultado <= saida_calc;
                erro      <= erro_pend;
            end
            resultado_valido <= captura;
            expirou          <= estouro;
        end
    end

endmodule

// File: tb/tb_sequenciador_calculadora.sv
// Directed bench for the calculator sequencer with a behavioural calculator
// on saida_calc and hand-computed expected results.
module tb_sequenciador_calculadora;
    import calculadora_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] entrada_A, entrada_B, saida_calc, resultado;
    logic [2:0] codigo;
    logic       resultado_valido, erro, expirou;

    int checks = 0;
    int erros  = 0;

    sequenciador_calculadora_if bus ();

    sequenciador_calculadora #(.TIMEOUT(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .fluxo            (bus.slave),
        .entrada_A        (entrada_A),
        .entrada_B        (entrada_B),
        .codigo           (codigo),
        .saida_calc       (saida_calc),
        .resultado        (resultado),
        .resultado_valido (resultado_valido),
        .erro             (erro),
        .expirou          (expirou)
    );

    always_comb begin
        saida_calc = 8'h00;
        case (codigo)
            MOSTRA_A: saida_calc = entrada_A;
            MOSTRA_B: saida_calc = entrada_B;
            SOMAR:    saida_calc = entrada_A + entrada_B;
            SUBTRAIR: saida_calc = entrada_A - entrada_B;
            default:  saida_calc = 8'h00;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, esp);
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    task automatic enviar(input logic [7:0] b);
        int n;
        n = 0;
        bus.dado_in     = b;
        bus.dado_valido = 1'b1;
        while (!bus.dado_pronto && n < 20) begin
            ciclo();
            n++;
        end
        if (n >= 20) verifica("espera_pronto", {31'd0, bus.dado_pronto}, 32'd1);
        ciclo();
        bus.dado_valido = 1'b0;
    endtask

    // Called right after the opcode edge; checks the result pulse and its width.
    task automatic espera_resultado(input string tag, input logic [7:0] res, input logic err);
        ciclo();
        verifica({tag, "_valido"}, {31'd0, resultado_valido}, 32'd1);
        verifica({tag, "_res"}, {24'd0, resultado}, {24'd0, res});
        verifica({tag, "_erro"}, {31'd0, erro}, {31'd0, err});
        ciclo();
        verifica({tag, "_pulso"}, {31'd0, resultado_valido}, 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.dado_in     = 8'h00;
        bus.dado_valido = 1'b0;
        bus.usar_ultimo = 1'b0;
        ciclo();
        verifica("rst_A", {24'd0, entrada_A}, 32'h00);
        verifica("rst_res", {24'd0, resultado}, 32'h00);
        verifica("rst_cod", {29'd0, codigo}, 32'd0);
        verifica("rst_valido", {31'd0, resultado_valido}, 32'd0);
        verifica("rst_pronto", {31'd0, bus.dado_pronto}, 32'd1);
        rst = 1'b0;

        // 5 + 3, opcode held high through CALCULA/RESULTADO with a different byte behind it
        enviar(8'h05);
        enviar(8'h03);
        bus.dado_in     = 8'h03;
        bus.dado_valido = 1'b1;
        ciclo();
        bus.dado_in = 8'h55;
        verifica("soma_cod", {29'd0, codigo}, {29'd0, SOMAR});
        verifica("soma_pronto_n", {31'd0, bus.dado_pronto}, 32'd0);
        verifica("soma_antes", {31'd0, resultado_valido}, 32'd0);
        ciclo();
        verifica("soma_res", {24'd0, resultado}, 32'h08);
        verifica("soma_valido", {31'd0, resultado_valido}, 32'd1);
        verifica("soma_erro", {31'd0, erro}, 32'd0);
        verifica("soma_pronto_n1", {31'd0, bus.dado_pronto}, 32'd0);
        ciclo();
        verifica("soma_pulso", {31'd0, resultado_valido}, 32'd0);
        verifica("soma_pronto_n2", {31'd0, bus.dado_pronto}, 32'd1);
        verifica("bp_A", {24'd0, entrada_A}, 32'h05);
        verifica("bp_B", {24'd0, entrada_B}, 32'h03);
        bus.dado_valido = 1'b0;

        // chain: previous result as A while 0x77 is offered but must not be taken
        bus.usar_ultimo = 1'b1;
        bus.dado_in     = 8'h77;
        bus.dado_valido = 1'b1;
        #1;
        verifica("enc_pronto", {31'd0, bus.dado_pronto}, 32'd0);
        ciclo();
        bus.usar_ultimo = 1'b0;
        bus.dado_valido = 1'b0;
        verifica("enc_A", {24'd0, entrada_A}, 32'h08);
        verifica("enc_B_intacto", {24'd0, entrada_B}, 32'h03);
        enviar(8'h02);
        verifica("enc_B", {24'd0, entrada_B}, 32'h02);
        enviar(8'h04);
        espera_resultado("enc", 8'h06, 1'b0);

        // wrap-around both directions
        enviar(8'hFF); enviar(8'h02); enviar(8'h03);
        espera_resultado("wrap_soma", 8'h01, 1'b0);
        enviar(8'h03); enviar(8'h05); enviar(8'h04);
        espera_resultado("wrap_sub", 8'hFE, 1'b0);

        // invalid opcodes, then a valid one clears erro
        enviar(8'h09); enviar(8'h04); enviar(8'h07);
        verifica("inv7_cod", {29'd0, codigo}, 32'd0);
        espera_resultado("inv7", 8'h00, 1'b1);
        enviar(8'h09); enviar(8'h04); enviar(8'h0B);
        espera_resultado("invB", 8'h00, 1'b1);
        enviar(8'h09); enviar(8'h04); enviar(8'h01);
        verifica("mostra_cod", {29'd0, codigo}, {29'd0, MOSTRA_A});
        espera_resultado("mostra", 8'h09, 1'b0);

        // timeout in ESPERA_B after 8 idle cycles
        enviar(8'h10);
        for (int i = 0; i < 7; i++) ciclo();
        verifica("to_cedo", {31'd0, expirou}, 32'd0);
        ciclo();
        verifica("to_expirou", {31'd0, expirou}, 32'd1);
        verifica("to_res", {24'd0, resultado}, 32'h09);
        ciclo();
        verifica("to_pulso", {31'd0, expirou}, 32'd0);
        enviar(8'h20);
        verifica("to_novo_A", {24'd0, entrada_A}, 32'h20);
        verifica("to_B_intacto", {24'd0, entrada_B}, 32'h04);
        enviar(8'h01); enviar(8'h03);
        espera_resultado("to_soma", 8'h21, 1'b0);

        // asynchronous reset while waiting for the opcode
        enviar(8'hAA);
        enviar(8'hBB);
        #2 rst = 1'b1;
        #1;
        verifica("arst_A", {24'd0, entrada_A}, 32'h00);
        verifica("arst_B", {24'd0, entrada_B}, 32'h00);
        verifica("arst_res", {24'd0, resultado}, 32'h00);
        verifica("arst_pronto", {31'd0, bus.dado_pronto}, 32'd1);
        ciclo();
        rst = 1'b0;
        enviar(8'h09);
        verifica("arst_prim_A", {24'd0, entrada_A}, 32'h09);
        enviar(8'h04); enviar(8'h03);
        espera_resultado("arst_soma", 8'h0D, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, erros);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sequenciador_calculadora.md
Name: sequenciador_calculadora

Overview:
- Upstream stage of the 8-bit combinational calculator: accepts a byte stream (operand A, operand B, opcode) over a valid/ready handshake.
- Drives registered entrada_A/entrada_B/codigo into the calculator and captures its saida one cycle later into a result register with a valid pulse.
- Supports chaining the previous result as operand A and aborting stalled sequences by inactivity timeout.
- Does not instantiate the calculator; the top level connects the two.

Parameters:
- TIMEOUT, 1000: idle cycles allowed in ESPERA_B/ESPERA_COD before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- dado_in  input  8  incoming byte (A, B or opcode, by state)
- dado_valido  input  1  dado_in valid
- dado_pronto  output  1  block can accept a byte; transfer = dado_valido & dado_pronto
- usar_ultimo  input  1  in ESPERA_A, load resultado as A instead of a byte
- entrada_A  output  8  registered operand A to calculator
- entrada_B  output  8  registered operand B to calculator
- codigo  output  3  registered opcode to calculator
- saida_calc  input  8  calculator output (combinational from the three above)
- resultado  output  8  captured result
- resultado_valido  output  1  one-cycle pulse when resultado updates
- erro  output  1  last opcode was invalid; valid alongside resultado
- expirou  output  1  one-cycle pulse on timeout abort

Behaviour:
- Single clock domain. Reset is asynchronous and active-high on rst. On reset: state ESPERA_A, entrada_A/entrada_B/resultado = 0x00, codigo = 000, resultado_valido/erro/expirou = 0, idle counter = 0.
- FSM states: ESPERA_A, ESPERA_B, ESPERA_COD, CALCULA, RESULTADO.
- dado_pronto is 1 in ESPERA_A, ESPERA_B and ESPERA_COD; 0 in CALCULA and RESULTADO. In ESPERA_A, dado_pronto = ~usar_ultimo.
- ESPERA_A, transfer: entrada_A <= dado_in, go to ESPERA_B.
- ESPERA_A, usar_ultimo = 1: entrada_A <= resultado, go to ESPERA_B, no byte consumed. usar_ultimo takes priority over dado_valido.
- ESPERA_B, transfer: entrada_B <= dado_in, go to ESPERA_COD.
- ESPERA_COD, transfer: go to CALCULA.
  - Valid opcode (dado_in[7:3] == 0 and dado_in[2:0] <= 3'b100): codigo <= dado_in[2:0], erro_next = 0.
  - Otherwise: codigo <= 3'b000, erro_next = 1.
- CALCULA (1 cycle): at its closing edge, resultado <= saida_calc, erro <= erro_next, resultado_valido <= 1; go to RESULTADO.
- RESULTADO (1 cycle): resultado_valido <= 0 at its closing edge; go to ESPERA_A.
- Latency: opcode accepted at edge N; resultado/resultado_valido visible after edge N+1; dado_pronto high again after edge N+2.
- Bytes presented during CALCULA/RESULTADO are not accepted; the source holds them.
- entrada_A, entrada_B and codigo hold their values until overwritten; erro holds until the next result capture.
- Arithmetic is performed by the calculator, mod 256. The block adds no width extension.
- Timeout (TIMEOUT > 0):
  - Counter increments each cycle in ESPERA_B/ESPERA_COD without a transfer; it clears on a transfer or any state change.
  - When the counter reaches TIMEOUT: go to ESPERA_A, expirou = 1 for one cycle, counter = 0. Operand registers keep stale values; resultado is unchanged.
  - If a transfer and timeout occur in the same cycle, the transfer wins and no abort happens.
- Reset mid-operation: all state and outputs return to reset values immediately, regardless of the clock. The partially entered sequence is discarded.

Decomposition:
- Package calculadora_pkg:
  - Opcode localparams: ZERAR=000, MOSTRA_A=001, MOSTRA_B=010, SOMAR=011, SUBTRAIR=100, plus COD_MAX=100.
  - FSM state encoding.
  - The calculator adopts the same package.
- One sub-module, temporizador_inatividade:
  - Parameterized by TIMEOUT; inputs clk, rst, contar, limpar; output estouro.
  - Generates nothing when TIMEOUT = 0.

Test Plan:
- A=0x05, B=0x03, opcode 0x03 → resultado=0x08, erro=0, resultado_valido high exactly one cycle, asserted after edge N+1; dado_pronto low for 2 cycles.
- Wrap-around: 0xFF+0x02 (op 0x03) → 0x01; then 0x03−0x05 (op 0x04) → 0xFE.
- Chaining: after resultado=0x08, usar_ultimo=1 with dado_valido=1 (byte 0x77 held), then B=0x02, opcode 0x04 → entrada_A=0x08, 0x77 not consumed in that cycle, resultado=0x06.
- Invalid opcodes:
  - 0x07 → resultado=0x00, erro=1, codigo=000.
  - 0x0B → erro=1.
  - A following valid op → erro=0.
- Timeout with TIMEOUT=8: accept A=0x10, hold dado_valido=0 for 8 cycles → expirou pulse, state ESPERA_A; the next byte 0x20 loads entrada_A.
- Reset and backpressure:
  - Assert rst asynchronously in ESPERA_COD → outputs zero with no clock edge; after release, dado_pronto=1 and the first byte is taken as A.
  - dado_valido held high through CALCULA → no extra transfer.
